// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bus_arbiter
//  Purpose  : Shares one SRAM-like memory port between the instruction-fetch
//             requester (inst) and the load/store requester (data). Grants at
//             most one address per cycle, remembers the owner of every
//             accepted address in an in-order ID FIFO and routes each
//             returned data_ok/rdata back to the requester that issued it.
//  Options  : ARB_RR_EN - when defined, contention between the two
//             requesters is resolved round-robin using a last_grant register;
//             when undefined, data has fixed priority over inst.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    // Pointer width; a depth-1 FIFO still needs a 1-bit pointer that stays 0.
    localparam int              PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(MAX_OUTSTANDING);

    // Address-phase lock: idle, or holding the grant for one requester
    // until the memory accepts its address.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } lock_state_t;

    lock_state_t              r_state;
    lock_state_t              w_state_next;

    logic                     r_post_rst;
    logic [MAX_OUTSTANDING-1:0] r_fifo;      // owner per slot: 0=inst, 1=data
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic                     w_blocked;
    logic                     w_locked;
    logic                     w_lock_sel;
    logic                     w_pick;
    logic                     w_sel;
    logic                     w_sel_req;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_head;

`ifdef ARB_RR_EN
    logic                     r_last_grant;

    // Remember who won the most recent address handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (w_push) begin
            r_last_grant <= w_sel;
        end
    end

    // Round-robin choice among unlocked requesters: on contention the one
    // that did not win last time goes first.
    always_comb begin
        w_pick = data_req;
        if (inst_req && data_req) begin
            w_pick = ~r_last_grant;
        end
    end
`else
    // Fixed priority: data wins whenever it is requesting.
    always_comb begin
        w_pick = data_req;
    end
`endif

    // Hold the request path quiet during reset and for the cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_post_rst <= 1'b1;
        end else begin
            r_post_rst <= 1'b0;
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock next-state and decode of the locked requester.
    always_comb begin
        w_state_next = r_state;
        w_locked     = 1'b0;
        w_lock_sel   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    w_state_next = w_sel ? ST_LOCK_DATA : ST_LOCK_INST;
                end
            end
            ST_LOCK_INST: begin
                w_locked   = 1'b1;
                w_lock_sel = 1'b0;
                if (w_push) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOCK_DATA: begin
                w_locked   = 1'b1;
                w_lock_sel = 1'b1;
                if (w_push) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request-side selection and the shared memory request mux.
    always_comb begin
        w_blocked = reset | r_post_rst;
        w_full    = (r_count == c_cnt_full);
        w_sel     = w_locked ? w_lock_sel : w_pick;
        w_sel_req = w_sel ? data_req : inst_req;
        // No bypass: a pop in the same cycle does not free a slot early.
        mem_req   = w_sel_req && !w_full && !w_blocked;
        mem_wr    = w_sel ? data_wr    : inst_wr;
        mem_size  = w_sel ? data_size  : inst_size;
        mem_addr  = w_sel ? data_addr  : inst_addr;
        mem_wstrb = w_sel ? data_wstrb : inst_wstrb;
        mem_wdata = w_sel ? data_wdata : inst_wdata;
        w_push    = mem_req && mem_addr_ok;
        inst_addr_ok = w_push && !w_sel;
        data_addr_ok = w_push &&  w_sel;
    end

    // Response routing: the FIFO head names the owner of the returning beat.
    always_comb begin
        w_pop        = mem_data_ok && (r_count != '0) && !reset;
        w_head       = r_fifo[r_rd_ptr];
        inst_data_ok = w_pop && !w_head;
        data_data_ok = w_pop &&  w_head;
        inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
        data_rdata   = data_data_ok ? mem_rdata : 32'd0;
    end

    // Outstanding-owner FIFO: pointers wrap at the configured depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_bus_arbiter
//  Purpose  : Self-checking bench for sram_bus_arbiter. Directed scenarios
//             followed by randomized traffic; a transaction-level model holds
//             the queue of outstanding owners and the lock/grant rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 0, data_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic [3:0]  inst_wstrb = 0, data_wstrb = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;

    int checks = 0;
    int failures = 0;

    // Model state: owners of accepted-but-unanswered addresses, in order.
    int  sb[$];
    bit  locked = 0, lock_who = 0, last_grant = 0, was_rst = 0;
    bit  acc_inst = 0, acc_data = 0;
    bit  inst_pend = 0, data_pend = 0;

    sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor/model: sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin : monitor
        bit blocked, sel, sel_req, exp_req, hs, exp_pop;
        int owner;
        blocked = reset || was_rst;
        if (locked)                   sel = lock_who;
`ifdef ARB_RR_EN
        else if (inst_req && data_req) sel = !last_grant;
`else
        else if (inst_req && data_req) sel = 1'b1;
`endif
        else                          sel = data_req;
        sel_req = sel ? data_req : inst_req;
        exp_req = sel_req && !blocked && (sb.size() < MAXO);
        hs      = exp_req && mem_addr_ok;

        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
        if (exp_req) begin
            chk("mem_addr",  mem_addr,  sel ? data_addr  : inst_addr);
            chk("mem_wdata", mem_wdata, sel ? data_wdata : inst_wdata);
            chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
                sel ? {25'd0, data_wr, data_size, data_wstrb} : {25'd0, inst_wr, inst_size, inst_wstrb});
        end
        chk("addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, hs && !sel, hs && sel});

        // Scoreboard side: any beat presented by the DUT consumes the head.
        exp_pop = mem_data_ok && !reset && (sb.size() > 0);
        chk("data_ok_any", {31'd0, inst_data_ok | data_data_ok}, {31'd0, exp_pop});
        if (exp_pop) begin
            owner = sb.pop_front();
            chk("route", {30'd0, inst_data_ok, data_data_ok}, {30'd0, owner == 0, owner == 1});
            chk("rdata_tgt", owner ? data_rdata : inst_rdata, mem_rdata);
            chk("rdata_other", owner ? inst_rdata : data_rdata, 32'd0);
        end

        if (exp_req && !mem_addr_ok) begin
            locked = 1; lock_who = sel;
        end
        if (hs) begin
            sb.push_back(int'(sel));
            locked = 0; last_grant = sel;
        end
        acc_inst = hs && !sel;
        acc_data = hs && sel;
        if (reset) begin
            sb.delete(); locked = 0; lock_who = 0; last_grant = 0;
        end
        was_rst = reset;
    end

    task automatic new_inst(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [3:0] st, input logic [31:0] d);
        inst_pend = 1; inst_addr = a; inst_wr = w; inst_size = s; inst_wstrb = st; inst_wdata = d;
    endtask

    task automatic new_data(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [3:0] st, input logic [31:0] d);
        data_pend = 1; data_addr = a; data_wr = w; data_size = s; data_wstrb = st; data_wdata = d;
    endtask

    // One bus cycle: requesters hold req until their address is accepted.
    task automatic step(input bit aok, input bit dok, input logic [31:0] rd);
        inst_req = inst_pend; data_req = data_pend;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
        @(posedge clk); #1;
        if (acc_inst) inst_pend = 0;
        if (acc_data) data_pend = 0;
    endtask

    initial begin
        // Reset with a request already waiting; it must not be granted early.
        reset = 1;
        new_inst(32'h1c000000, 0, 2'd2, 4'hf, 32'd0);
        step(1, 0, 0);
        step(1, 0, 0);
        reset = 0;
        step(1, 0, 0);                  // first cycle after reset: blocked
        step(1, 0, 0);                  // inst accepted
        step(0, 0, 0);
        step(0, 1, 32'h02800c0c);       // inst response

        // Contention, then full, then a freed slot.
        new_inst(32'h1c000010, 0, 2'd2, 4'hf, 32'd0);
        new_data(32'h80000000, 1, 2'd2, 4'hf, 32'h12345678);
        step(1, 0, 0);
        step(1, 0, 0);
        new_data(32'h80000004, 0, 2'd1, 4'h3, 32'd0);
        step(1, 0, 0);                  // full: no request
        step(1, 1, 32'hcafe0001);       // pop but still full this cycle
        step(1, 0, 0);                  // now accepted
        step(0, 1, 32'hcafe0002);
        step(0, 1, 32'hcafe0003);
        step(0, 1, 32'hdeadbeef);       // spurious, FIFO empty

        // Lock hold while memory stalls; inst arrives during the stall.
        new_data(32'h1c008000, 0, 2'd2, 4'hf, 32'd0);
        step(0, 0, 0);
        new_inst(32'h1c000020, 0, 2'd2, 4'hf, 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 32'h11111111);
        step(0, 1, 32'h22222222);

        // Alternating owners so the pointers wrap.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) new_inst(32'h1c000100 + k, 0, 2'd2, 4'hf, 32'd0);
            else            new_data(32'h80000100 + k, 0, 2'd0, 4'h1, 32'd0);
            step(1, 0, 0);
            step(0, 1, $urandom);
        end

        // Reset with two outstanding; later responses must be dropped.
        new_inst(32'h1c000200, 0, 2'd2, 4'hf, 32'd0);
        new_data(32'h80000200, 0, 2'd2, 4'hf, 32'd0);
        step(1, 0, 0);
        step(1, 0, 0);
        reset = 1;
        step(0, 1, 32'h33333333);
        reset = 0;
        step(0, 1, 32'h44444444);
        step(0, 1, 32'h55555555);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!inst_pend && $urandom_range(0, 2) == 0)
                new_inst($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                         4'($urandom), $urandom);
            if (!data_pend && $urandom_range(0, 1) == 0)
                new_data($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                         4'($urandom), $urandom);
            reset = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 2) != 0,
                 (sb.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0),
                 $urandom);
        end
        reset = 0;
        for (int c = 0; c < 6; c++) step(0, 1, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst) and the load/store requester (data).
- Sits between the pipeline front/back ends and the memory bridge.
- Grants one address request per cycle and tracks outstanding transactions in an in-order ID FIFO.
- Routes each returned data_ok/rdata to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2: depth of the outstanding-ID FIFO (power of 2, >=1).
- CNT_W, 2: width of the FIFO occupancy counter; must hold 0..MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  inst address request
- inst_wr  in  1  inst write (normally 0)
- inst_size  in  2  access size: 0=byte, 1=half, 2=word
- inst_addr  in  32  inst address
- inst_wstrb  in  4  byte strobes
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst address accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data requester, same meanings as inst
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- mem_req  out  1  shared request
- mem_wr  out  1  shared write
- mem_size  out  2  shared size
- mem_addr  out  32  shared address
- mem_wstrb  out  4  shared strobes
- mem_wdata  out  32  shared write data
- mem_addr_ok  in  1  memory accepted address
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: FIFO empty (count=0, rd/wr pointers 0), lock=0, lock_sel=0.
  - mem_req=0, all *_addr_ok=0, all *_data_ok=0 while reset is high and in the first cycle after.
- Selection, when lock=0:
  - sel=data if data_req, else inst if inst_req.
  - Default: data has fixed priority.
- Lock: once mem_req is driven and mem_addr_ok=0, set lock=1 and lock_sel=sel.
  - While lock=1, mem_* is driven from lock_sel's requester only. The address is stable until accepted.
  - The locked requester must hold its req; dropping it is a protocol violation and is not checked.
- mem_req = (selected req) && !full.
  - mem_* fields are a mux of the selected requester's inputs, combinational.
- Address handshake fires when mem_req && mem_addr_ok.
  - Same cycle, combinational: sel_addr_ok=1; the other requester's addr_ok=0.
  - Push sel (0=inst, 1=data) into the FIFO and clear lock.
- full = (count==MAX_OUTSTANDING).
  - When full, mem_req=0 even if a pop occurs in the same cycle; there is no bypass.
- Response: when mem_data_ok=1 and count>0:
  - Pop the head. head==1 -> data_data_ok=1 and data_rdata=mem_rdata; head==0 -> inst_data_ok=1 and inst_rdata=mem_rdata.
  - Response path is combinational, zero latency.
  - The non-target *_rdata is don't-care; drive 0.
- mem_data_ok with count==0: ignored. No pop, both data_ok=0.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping mod MAX_OUTSTANDING.
- Responses return strictly in issue order. A write's data_ok is routed the same way as a read's.
- Reset asserted mid-transaction: all state is cleared and in-flight responses are dropped. The memory side must be reset together with this block.

Optional Feature:
- Macro: ARB_RR_EN
- Defined: round-robin policy. A last_grant register (reset 0=inst) updates on every address handshake.
  - When both requesters are active and lock=0, grant goes to the one not equal to last_grant.
- Undefined: fixed data-over-inst priority; no last_grant register.

Test Plan:
- Single inst read: inst_req=1, addr=0x1c000000, mem_addr_ok=1 in the same cycle.
  - inst_addr_ok=1 that cycle, mem_addr=0x1c000000.
  - 2 cycles later, mem_data_ok=1, rdata=0x02800c0c -> inst_data_ok=1, inst_rdata=0x02800c0c, data_data_ok=0.
- Contention: inst_req=data_req=1 in the same cycle with mem_addr_ok=1.
  - Default build: data granted first, inst granted the next cycle.
  - ARB_RR_EN build, last_grant=1: inst granted first.
- Lock hold: data_req=1 (addr 0x1c008000), mem_addr_ok=0 for 3 cycles; inst_req rises in cycle 2.
  - mem_addr stays 0x1c008000 throughout; data_addr_ok=1 only when mem_addr_ok rises.
- Full: MAX_OUTSTANDING=2, two accepted requests, no responses yet.
  - Third req -> mem_req=0 and addr_ok=0.
  - After one mem_data_ok, mem_req=1 the next cycle.
- Ordering and wrap: issue inst, data, inst, data with responses returning one by one.
  - data_ok routed in order inst, data, inst, data; pointers wrap correctly.
  - Spurious mem_data_ok with FIFO empty -> no *_data_ok asserted.
- Reset mid-flight: 2 outstanding, assert reset 1 cycle.
  - count=0 and mem_req=0 during reset.
  - Next mem_data_ok is ignored.
